// File: rtl/data_sync_buf.sv
// Enable synchroniser with level/toggle event detection, word capture, and a small output FIFO.
// Overflow is sticky until cleared; a drop coinciding with a clear keeps the flag set.
module data_sync_buf #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned TOGGLE_MODE = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          bus_enable,
  input  logic [BUS_WIDTH-1:0]          unsync_bus,
  input  logic                          out_ready,
  input  logic                          clr_ovf,
  output logic                          enable_pulse,
  output logic [BUS_WIDTH-1:0]          sync_bus,
  output logic                          out_valid,
  output logic [BUS_WIDTH-1:0]          out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  pulse_q, pulse_d;
  logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
  logic [BUS_WIDTH-1:0]  out_data_q, out_data_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         count_q, count_d, avail;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic [BUS_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic last, event_c, pop, full, do_push, drop;

  // Synchroniser, event detection and FIFO next-state
  always_comb begin
    sync_d     = {sync_q[NUM_STAGES-2:0], bus_enable};
    last       = sync_q[NUM_STAGES-1];
    prev_d     = last;
    event_c    = (TOGGLE_MODE != 0) ? (last ^ prev_q) : (last & ~prev_q);
    pulse_d    = event_c;
    sync_bus_d = event_c ? unsync_bus : sync_bus_q;

    pop     = valid_q & out_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    do_push = event_c & (~full | pop);
    drop    = event_c & full & ~pop;
    avail   = count_q - CW'(pop);
    count_d = avail + CW'(do_push);
    rd_d    = rd_q + PW'(pop);
    wr_d    = wr_q + PW'(do_push);
    valid_d = (count_d != '0);

    // Head register: pushed word goes straight to head only when nothing older remains
    out_data_d = out_data_q;
    if (count_d != '0) begin
      out_data_d = (avail == '0) ? unsync_bus : mem_q[rd_d];
    end

    ovf_d = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      pulse_q    <= 1'b0;
      sync_bus_q <= '0;
      out_data_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      pulse_q    <= pulse_d;
      sync_bus_q <= sync_bus_d;
      out_data_q <= out_data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_q] <= unsync_bus;
    end
  end

  assign enable_pulse = pulse_q;
  assign sync_bus     = sync_bus_q;
  assign out_valid    = valid_q;
  assign out_data     = out_data_q;
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_data_sync_buf.sv
// Scoreboard bench for data_sync_buf: a level-mode default instance and a toggle-mode wide instance.
module tb_data_sync_buf;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        en0, rdy0, clr0, pulse0, val0, ovf0;
  logic [7:0]  bus0, sbus0, odata0;
  logic [2:0]  cnt0;
  logic        en1, rdy1, clr1, pulse1, val1, ovf1;
  logic [15:0] bus1, sbus1, odata1;
  logic [2:0]  cnt1;

  data_sync_buf dut0 (
    .CLK(CLK), .RST(RST), .bus_enable(en0), .unsync_bus(bus0), .out_ready(rdy0),
    .clr_ovf(clr0), .enable_pulse(pulse0), .sync_bus(sbus0), .out_valid(val0),
    .out_data(odata0), .fifo_count(cnt0), .overflow(ovf0)
  );

  data_sync_buf #(.BUS_WIDTH(16), .NUM_STAGES(3), .TOGGLE_MODE(1), .FIFO_DEPTH(4)) dut1 (
    .CLK(CLK), .RST(RST), .bus_enable(en1), .unsync_bus(bus1), .out_ready(rdy1),
    .clr_ovf(clr1), .enable_pulse(pulse1), .sync_bus(sbus1), .out_valid(val1),
    .out_data(odata1), .fifo_count(cnt1), .overflow(ovf1)
  );

  int checks = 0;
  int failures = 0;
  int pcnt0 = 0;
  int pcnt1 = 0;
  logic [7:0]  q0[$];
  logic [15:0] q1[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted output word is compared against the oldest expected word
  always @(negedge CLK) begin
    if (!RST && val0 && rdy0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop0_unexpected actual=%0h required=none", odata0);
      end else begin
        chk("pop0_order", 32'(odata0), 32'(q0.pop_front()));
      end
    end
    if (!RST && val1 && rdy1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop1_unexpected actual=%0h required=none", odata1);
      end else begin
        chk("pop1_order", 32'(odata1), 32'(q1.pop_front()));
      end
    end
    if (pulse0) pcnt0++;
    if (pulse1) pcnt1++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic level_event0(input logic [7:0] d);
    en0  = 1'b1;
    bus0 = d;
    repeat (3) tick();
    en0 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic toggle1(input logic [15:0] d);
    bus1 = d;
    en1  = ~en1;
    q1.push_back(d);
    repeat (3) begin
      tick();
      chk("tog_pulse_early", 32'(pulse1), 32'd0);
    end
    tick();
    chk("tog_pulse", 32'(pulse1), 32'd1);
    chk("tog_sync_bus", 32'(sbus1), 32'(d));
    tick();
    chk("tog_pulse_single", 32'(pulse1), 32'd0);
  endtask

  initial begin
    int p;
    RST = 1'b1;
    en0 = 1'b0; bus0 = '0; rdy0 = 1'b0; clr0 = 1'b0;
    en1 = 1'b0; bus1 = '0; rdy1 = 1'b0; clr1 = 1'b0;
    repeat (2) tick();
    chk("rst_pulse", 32'(pulse0), 32'd0);
    chk("rst_sync_bus", 32'(sbus0), 32'd0);
    chk("rst_valid", 32'(val0), 32'd0);
    chk("rst_out_data", 32'(odata0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_overflow", 32'(ovf0), 32'd0);
    RST = 1'b0;
    tick();

    // Held enable: one event, pulse after the third edge
    en0 = 1'b1; bus0 = 8'hCC; q0.push_back(8'hCC);
    tick(); chk("t1_pulse_k", 32'(pulse0), 32'd0);
    tick(); chk("t1_pulse_k1", 32'(pulse0), 32'd0);
    tick();
    chk("t1_pulse_k2", 32'(pulse0), 32'd1);
    chk("t1_sync_bus", 32'(sbus0), 32'hCC);
    chk("t1_count", 32'(cnt0), 32'd1);
    chk("t1_out_data", 32'(odata0), 32'hCC);
    chk("t1_valid", 32'(val0), 32'd1);
    tick(); chk("t1_pulse_k3", 32'(pulse0), 32'd0);
    en0 = 1'b0;

    // Short low gap, second event, drain in order
    tick();
    en0 = 1'b1; bus0 = 8'hD8; rdy0 = 1'b1; q0.push_back(8'hD8);
    repeat (6) tick();
    chk("t2_sync_bus", 32'(sbus0), 32'hD8);
    chk("t2_pulses", 32'(pcnt0), 32'd2);
    chk("t2_valid", 32'(val0), 32'd0);
    chk("t2_count", 32'(cnt0), 32'd0);
    chk("t2_drained", 32'(q0.size()), 32'd0);
    en0 = 1'b0;
    repeat (3) tick();

    // Overflow: five events into a depth-4 buffer with no consumer
    rdy0 = 1'b0;
    for (int i = 1; i <= 4; i++) q0.push_back(8'(i));
    for (int i = 1; i <= 5; i++) level_event0(8'(i));
    chk("t3_count", 32'(cnt0), 32'd4);
    chk("t3_overflow", 32'(ovf0), 32'd1);
    chk("t3_out_data", 32'(odata0), 32'h01);
    chk("t3_sync_bus", 32'(sbus0), 32'h05);
    chk("t3_pulses", 32'(pcnt0), 32'd7);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("t3_clr_ovf", 32'(ovf0), 32'd0);
    chk("t3_count_kept", 32'(cnt0), 32'd4);

    // Full buffer with push and pop on the same edge
    q0.push_back(8'h06);
    en0 = 1'b1; bus0 = 8'h06;
    tick(); tick();
    rdy0 = 1'b1;
    tick();
    chk("t4_count", 32'(cnt0), 32'd4);
    chk("t4_overflow", 32'(ovf0), 32'd0);
    chk("t4_sync_bus", 32'(sbus0), 32'h06);
    en0 = 1'b0;
    repeat (8) tick();
    chk("t4_valid", 32'(val0), 32'd0);
    chk("t4_drained", 32'(q0.size()), 32'd0);

    // Reset mid-transfer with an event in flight
    rdy0 = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      q0.push_back(8'(i));
      level_event0(8'(i));
    end
    chk("t5_count", 32'(cnt0), 32'd3);
    en0 = 1'b1; bus0 = 8'h0A;
    tick();
    RST = 1'b1; en0 = 1'b0;
    #1;
    chk("t5_rst_pulse", 32'(pulse0), 32'd0);
    chk("t5_rst_sync_bus", 32'(sbus0), 32'd0);
    chk("t5_rst_valid", 32'(val0), 32'd0);
    chk("t5_rst_out_data", 32'(odata0), 32'd0);
    chk("t5_rst_count", 32'(cnt0), 32'd0);
    chk("t5_rst_overflow", 32'(ovf0), 32'd0);
    q0.delete();
    p = pcnt0;
    tick();
    RST = 1'b0;
    repeat (5) tick();
    chk("t5_no_pulse", 32'(pcnt0), 32'(p));
    chk("t5_count_after", 32'(cnt0), 32'd0);

    // Enable already high across reset release gives one event
    RST = 1'b1; en0 = 1'b1; bus0 = 8'h0C; rdy0 = 1'b1; q0.push_back(8'h0C);
    tick();
    RST = 1'b0;
    tick(); tick();
    chk("t6_pulse_early", 32'(pulse0), 32'd0);
    tick();
    chk("t6_pulse", 32'(pulse0), 32'd1);
    chk("t6_sync_bus", 32'(sbus0), 32'h0C);
    repeat (4) tick();
    chk("t6_one_pulse", 32'(pcnt0), 32'(p + 1));
    chk("t6_valid", 32'(val0), 32'd0);
    chk("t6_drained", 32'(q0.size()), 32'd0);
    en0 = 1'b0;

    // Toggle mode, three stages, 16-bit words
    rdy1 = 1'b1;
    toggle1(16'hA5A5);
    toggle1(16'h5A5A);
    toggle1(16'hFFFF);
    repeat (4) tick();
    chk("t7_pulses", 32'(pcnt1), 32'd3);
    chk("t7_valid", 32'(val1), 32'd0);
    chk("t7_drained", 32'(q1.size()), 32'd0);
    chk("t7_overflow", 32'(ovf1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
